player_stream: RTL
==================

// Module: player_stream
// PURPOSE
//  Streaming Spongent bit-permutation layer (pLayer): accepts the permutation-layer input state
//   CHUNK_BITS per beat, with forward or inverse permutation selected per transaction.
//  Scatters each bit into a full-width accumulator and presents the permuted state once complete.
//  Sits between the serial sBoxLayer output and the round-state register in the sponge datapath.
//  Replaces fixed 8-bit combinational per-index permutation logic with a parametrised, handshaked,
//   stateful version.
// PARAMETERS
//  STATE_BITS  88  permutation width b; must be a multiple of 4 and of CHUNK_BITS
//  CHUNK_BITS  8   input bits per accepted beat; N = STATE_BITS/CHUNK_BITS beats per state
// PORTS
//  clk        in   1             single clock, rising edge
//  rst        in   1             asynchronous reset, active-low (asserted when 0)
//  clr        in   1             synchronous abort: drop partial state, return to IDLE
//  in_valid   in   1             in_chunk/in_inv valid
//  in_ready   out  1             beat accepted when in_valid & in_ready
//  in_chunk   in   CHUNK_BITS    state bits k*CHUNK_BITS+CHUNK_BITS-1 .. k*CHUNK_BITS for beat k
//  in_inv     in   1             1 = inverse permutation; sampled only on beat 0
//  out_valid  out  1             out_state holds a complete permuted state
//  out_ready  in   1             consumer accepts out_state
//  out_state  out  STATE_BITS    permuted state
//  out_inv    out  1             mode the output was computed with
// BEHAVIOUR
//  Forward: P(j) = j*STATE_BITS/4 mod (STATE_BITS-1) for j < STATE_BITS-1; P(STATE_BITS-1) = STATE_BITS-1.
//  Inverse: P'(j) = 4*j mod (STATE_BITS-1) for j < STATE_BITS-1; P'(STATE_BITS-1) = STATE_BITS-1.
//  Compute index math at 32 bits; no truncation before the mod.
//  Beat k, bit i: input bit j = k*CHUNK_BITS + i is written to acc[P(j)] or acc[P'(j)] (assignment, not XOR).
//  FSM states:
//   IDLE: in_ready=1; on accept, clear acc, write beat 0, latch in_inv into mode, cnt=1 -> COLLECT
//    (-> FULL directly if N==1).
//   COLLECT: in_ready=1; on accept, write beat, cnt++; on beat N-1 -> FULL.
//   FULL: out_valid=1; in_ready=out_ready.
//    out handshake without input beat -> IDLE.
//    out handshake with simultaneous input beat -> treat the beat as beat 0 of the next state
//     (acc cleared then written, mode relatched) -> COLLECT.
//  Latency: out_valid rises the cycle after the N-th accepted beat; one state per N cycles sustained.
//  out_state and out_inv are stable while out_valid=1 and not out_ready.
//  cnt counts 0..N-1 and wraps to 0 on entering FULL or IDLE.
//  clr has priority over every handshake: acc=0, cnt=0, -> IDLE; any beat presented that cycle is dropped.
//  Reset (async, any state, incl. mid-transaction): state=IDLE, cnt=0, acc=0, mode=0,
//   out_valid=0, out_state=0, out_inv=0; in_ready=1 from the first cycle after deassertion.
//  in_valid with in_ready=0 has no effect; in_inv ignored on beats 1..N-1.
// STRUCTURE
//  Shared header constants.vh: default STATE_BITS per Spongent variant (88/136/176/240/272/336)
//   and the FSM state encodings IDLE/COLLECT/FULL.
//  One sub-module, pi_index: combinational, 32-bit idx + inv + STATE_BITS -> permuted index.
//   Instantiated CHUNK_BITS times, driven by cnt*CHUNK_BITS+i.
//  player_stream holds the FSM, cnt, mode and acc registers and the scatter decode.
// TESTING (STATE_BITS=88, CHUNK_BITS=8, N=11)
//  1. Forward: beat0=8'h02, rest 0 -> out_state=1<<22.
//     Repeat with beat0=8'h10 -> out_state=88'h2.
//     Repeat with beat10=8'h80 -> out_state=1<<87 (fixed point).
//  2. Inverse: beat2=8'h40 (bit 22), in_inv=1 -> out_state=88'h2, out_inv=1.
//     Random state forward then inverse -> original state.
//  3. Backpressure: hold out_ready=0 for 5 cycles after FULL -> out_state stable, in_ready=0, beats ignored.
//     Then out_ready=1 with in_valid=1 the same cycle -> that beat becomes beat 0 of next state;
//     next result correct, 11-cycle throughput.
//  4. Abort: clr after beat 5, then a full 11-beat state of 8'hFF -> out_state all ones, no leftover bits.
//     clr while FULL -> out_valid drops next cycle.
//  5. Reset: assert rst=0 mid-COLLECT and mid-FULL -> all outputs 0 immediately (async).
//     After release, a full state is produced correctly.
//  6. Bubbles: random in_valid gaps and random out_ready -> 1000 states match reference model P/P'.

Source files
------------

// File: rtl/player_stream_pkg.sv
// Shared constants, FSM encoding and helpers for the streaming Spongent pLayer.
// Imported by player_stream and player_stream_pi_index.
package player_stream_pkg;

    // Default state width b for each Spongent variant.
    localparam int SPONGENT_88_B  = 88;
    localparam int SPONGENT_136_B = 136;
    localparam int SPONGENT_176_B = 176;
    localparam int SPONGENT_240_B = 240;
    localparam int SPONGENT_272_B = 272;
    localparam int SPONGENT_336_B = 336;

    // Width used for all index arithmetic.
    localparam int PI_W = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FULL    = 2'd2
    } ps_state_e;

    // Number of beats that make up one state.
    function automatic int ps_beats(input int b, input int c);
        return b / c;
    endfunction

    // Width of a bit index into a b-bit state.
    function automatic int ps_idx_w(input int b);
        return (b > 1) ? $clog2(b) : 1;
    endfunction

    // Width of the beat counter.
    function automatic int ps_cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/player_stream_pi_index.sv
// Combinational Spongent pLayer index map: source bit idx -> destination bit.
// Ports: idx (32-bit source index), inv (1 = inverse map), pos (destination index).
module player_stream_pi_index
    import player_stream_pkg::*;
#(
    parameter int STATE_BITS = SPONGENT_88_B,
    parameter int IDX_W      = ps_idx_w(STATE_BITS)
) (
    input  logic [PI_W-1:0]  idx,
    input  logic             inv,
    output logic [IDX_W-1:0] pos
);

    localparam logic [PI_W-1:0] LAST = PI_W'(STATE_BITS - 1);
    localparam logic [PI_W-1:0] QTR  = PI_W'(STATE_BITS / 4);

    logic [PI_W-1:0] full;

    // Forward j*b/4 and inverse 4*j are both reduced mod b-1
    // at full 32-bit width; the top bit is a fixed point.
    always_comb begin
        full = '0;
        if (idx == LAST) begin
            full = LAST;
        end else if (inv) begin
            full = (idx << 2) % LAST;
        end else begin
            full = (idx * QTR) % LAST;
        end
    end

    assign pos = IDX_W'(full);

endmodule

// File: rtl/player_stream.sv
// Streaming Spongent bit-permutation layer: collects CHUNK_BITS per beat,
// scatters each bit to its permuted position, and presents the full state.
// Ports: clk, rst (async active-low), clr (sync abort),
//        in_valid/in_ready/in_chunk/in_inv (input beats, mode on beat 0),
//        out_valid/out_ready/out_state/out_inv (permuted state and its mode).
module player_stream
    import player_stream_pkg::*;
#(
    parameter int STATE_BITS = SPONGENT_88_B,
    parameter int CHUNK_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [CHUNK_BITS-1:0] in_chunk,
    input  logic                  in_inv,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [STATE_BITS-1:0] out_state,
    output logic                  out_inv
);

    localparam int N     = ps_beats(STATE_BITS, CHUNK_BITS);
    localparam int CNT_W = ps_cnt_w(N);
    localparam int IDX_W = ps_idx_w(STATE_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ps_state_e             state;
    logic [CNT_W-1:0]      cnt;
    logic                  mode;
    logic [STATE_BITS-1:0] acc;

    logic                  accept;
    logic                  beat_inv;
    logic [STATE_BITS-1:0] acc_wr;
    logic [PI_W-1:0]       idx [CHUNK_BITS];
    logic [IDX_W-1:0]      pos [CHUNK_BITS];

    // FULL only takes a beat when the result leaves the same cycle.
    assign in_ready  = (state != ST_FULL) | out_ready;
    assign accept    = in_valid & in_ready;
    assign out_valid = (state == ST_FULL);
    assign out_state = acc;
    assign out_inv   = mode;

    // Beat 0 (from IDLE or FULL) uses the incoming mode;
    // later beats use the latched one.
    assign beat_inv = (state == ST_COLLECT) ? mode : in_inv;

    // cnt is 0 in IDLE and FULL, so it is the beat number in all states.
    for (genvar g = 0; g < CHUNK_BITS; g++) begin : g_pi
        assign idx[g] = PI_W'(cnt) * PI_W'(CHUNK_BITS) + PI_W'(g);

        player_stream_pi_index #(
            .STATE_BITS (STATE_BITS),
            .IDX_W      (IDX_W)
        ) u_pi (
            .idx (idx[g]),
            .inv (beat_inv),
            .pos (pos[g])
        );
    end

    // Beat 0 starts from a cleared accumulator; later beats
    // overwrite their target bits in the partial state.
    always_comb begin
        acc_wr = (state == ST_COLLECT) ? acc : '0;
        for (int i = 0; i < CHUNK_BITS; i++) begin
            acc_wr[pos[i]] = in_chunk[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            cnt   <= '0;
            mode  <= 1'b0;
            acc   <= '0;
        end else if (clr) begin
            state <= ST_IDLE;
            cnt   <= '0;
            acc   <= '0;
        end else begin
            unique case (state)
                ST_IDLE, ST_FULL: begin
                    if (accept) begin
                        acc  <= acc_wr;
                        mode <= in_inv;
                        if (N == 1) begin
                            state <= ST_FULL;
                            cnt   <= '0;
                        end else begin
                            state <= ST_COLLECT;
                            cnt   <= CNT_ONE;
                        end
                    end else if (state == ST_FULL && out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                ST_COLLECT: begin
                    if (accept) begin
                        acc <= acc_wr;
                        if (cnt == CNT_LAST) begin
                            state <= ST_FULL;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule
